// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
// Sequences the uart_rx byte stream into command frames of the form
// HEADER, LEN, LEN payload bytes[, CHK]. Payload is buffered and only
// released over the frm_* valid/ready stream once the frame is complete.
// Bad LEN, checksum mismatch and inter-byte timeout abort the frame with
// a one-cycle frm_err pulse and a sticky err_code.
//
// Build option: define UART_FRM_CHK_EN to require and verify a trailing
// XOR checksum byte. Without it the frame ends after the last payload byte.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | hunting for HEADER, other bytes ignored
// S_LEN     | waiting for the LEN byte
// S_PAYLOAD | storing payload bytes into the buffer
// S_CHK     | waiting for the checksum byte (UART_FRM_CHK_EN only)
// S_DRAIN   | releasing the buffered payload, incoming bytes dropped

module uart_rx_frame_ctrl #(
  parameter int          CLK_FREQ      = 50_000_000,
  parameter int          BAUD          = 9600,
  parameter int          MAX_LEN       = 16,
  parameter logic [7:0]  HEADER        = 8'hA5,
  parameter int          TIMEOUT_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] frm_data,
  output logic       frm_valid,
  input  logic       frm_ready,
  output logic       frm_last,
  output logic [7:0] frm_len,
  output logic       frm_ok,
  output logic       frm_err,
  output logic [1:0] err_code,
  output logic       drop
);

  // One character is 10 bit times on the line.
  localparam int TIMEOUT_CLKS = (CLK_FREQ / BAUD) * 10 * TIMEOUT_BYTES;
  localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam int PW = $clog2(MAX_LEN + 1);
  // Buffer address width; pointers never exceed MAX_LEN-1 when used as addresses.
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_TMO = 2'd2;
`ifdef UART_FRM_CHK_EN
  localparam logic [1:0] ERR_CHK = 2'd3;
`endif

`ifdef UART_FRM_CHK_EN
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHK, S_DRAIN} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_DRAIN} state_t;
`endif

  state_t          state;
  logic [TW-1:0]   cnt;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [7:0]      buffer [0:MAX_LEN-1];
`ifdef UART_FRM_CHK_EN
  logic [7:0]      chk;
`endif

  logic tmo_hit;
  logic len_bad;
  logic wr_last;
  logic rd_last;

  assign tmo_hit = (cnt == TW'(TIMEOUT_CLKS - 1));
  assign len_bad = (rx_data == 8'd0) || (rx_data > 8'(MAX_LEN));
  assign wr_last = ((8'(wr_ptr) + 8'd1) == frm_len);
  assign rd_last = (8'(rd_ptr) == (frm_len - 8'd1));

  // Read side is a plain mux on the registered read pointer; forced to 0 outside DRAIN.
  assign frm_data = frm_valid ? buffer[rd_ptr[AW-1:0]] : 8'h00;
  assign frm_last = frm_valid & rd_last;

  // Payload storage, deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst && (state == S_PAYLOAD) && rx_done) begin
      buffer[wr_ptr[AW-1:0]] <= rx_data;
    end
  end

  // Frame sequencer with timeout and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      frm_len   <= '0;
      frm_valid <= 1'b0;
      frm_ok    <= 1'b0;
      frm_err   <= 1'b0;
      err_code  <= '0;
      drop      <= 1'b0;
`ifdef UART_FRM_CHK_EN
      chk       <= '0;
`endif
    end else begin
      frm_ok  <= 1'b0;
      frm_err <= 1'b0;
      drop    <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (rx_done && (rx_data == HEADER)) begin
            state <= S_LEN;
          end
        end

        S_LEN: begin
          if (rx_done) begin
            cnt <= '0;
            if (len_bad) begin
              frm_err  <= 1'b1;
              err_code <= ERR_LEN;
              state    <= S_IDLE;
            end else begin
              frm_len <= rx_data;
              wr_ptr  <= '0;
`ifdef UART_FRM_CHK_EN
              chk     <= rx_data;
`endif
              state   <= S_PAYLOAD;
            end
          end else if (tmo_hit) begin
            frm_err  <= 1'b1;
            err_code <= ERR_TMO;
            cnt      <= '0;
            state    <= S_IDLE;
          end else begin
            cnt <= cnt + TW'(1);
          end
        end

        S_PAYLOAD: begin
          if (rx_done) begin
            cnt    <= '0;
            wr_ptr <= wr_ptr + PW'(1);
`ifdef UART_FRM_CHK_EN
            chk    <= chk ^ rx_data;
            if (wr_last) begin
              state <= S_CHK;
            end
`else
            if (wr_last) begin
              frm_ok    <= 1'b1;
              frm_valid <= 1'b1;
              rd_ptr    <= '0;
              state     <= S_DRAIN;
            end
`endif
          end else if (tmo_hit) begin
            frm_err  <= 1'b1;
            err_code <= ERR_TMO;
            cnt      <= '0;
            state    <= S_IDLE;
          end else begin
            cnt <= cnt + TW'(1);
          end
        end

`ifdef UART_FRM_CHK_EN
        S_CHK: begin
          if (rx_done) begin
            cnt <= '0;
            if (rx_data == chk) begin
              frm_ok    <= 1'b1;
              frm_valid <= 1'b1;
              rd_ptr    <= '0;
              state     <= S_DRAIN;
            end else begin
              frm_err  <= 1'b1;
              err_code <= ERR_CHK;
              state    <= S_IDLE;
            end
          end else if (tmo_hit) begin
            frm_err  <= 1'b1;
            err_code <= ERR_TMO;
            cnt      <= '0;
            state    <= S_IDLE;
          end else begin
            cnt <= cnt + TW'(1);
          end
        end
`endif

        S_DRAIN: begin
          cnt  <= '0;
          // Receiver keeps running while we drain; those bytes are lost.
          drop <= rx_done;
          if (frm_ready) begin
            if (rd_last) begin
              frm_valid <= 1'b0;
              state     <= S_IDLE;
            end else begin
              rd_ptr <= rd_ptr + PW'(1);
            end
          end
        end

        default: begin
          frm_valid <= 1'b0;
          cnt       <= '0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl: stimulus pushes expected events
// and payload beats, a negedge monitor pops and compares them.
// Adapts to the UART_FRM_CHK_EN build option.

module tb_uart_rx_frame_ctrl;

  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 100;
  localparam int MAX_LEN  = 16;
  localparam int TBYTES   = 4;
  localparam int TC       = 400; // (1000/100)*10*4

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] frm_data;
  logic       frm_valid;
  logic       frm_ready;
  logic       frm_last;
  logic [7:0] frm_len;
  logic       frm_ok;
  logic       frm_err;
  logic [1:0] err_code;
  logic       drop;

  always #5 clk = ~clk;

  uart_rx_frame_ctrl #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .MAX_LEN(MAX_LEN),
    .HEADER(8'hA5), .TIMEOUT_BYTES(TBYTES)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
    .frm_data(frm_data), .frm_valid(frm_valid), .frm_ready(frm_ready),
    .frm_last(frm_last), .frm_len(frm_len), .frm_ok(frm_ok),
    .frm_err(frm_err), .err_code(err_code), .drop(drop)
  );

  typedef struct {
    int kind;  // 0 = ok, 1 = err
    int code;
    int cyc;   // -1 = any cycle
  } evt_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic [7:0] len;
  } beat_t;

  evt_t  exp_evt[$];
  beat_t exp_beat[$];
  int    exp_drops = 0;
  int    act_drops = 0;
  int    n_vec = 0;
  int    n_miss = 0;
  int    cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ok();
    evt_t e;
    e.kind = 0; e.code = 0; e.cyc = -1;
    exp_evt.push_back(e);
  endtask

  task automatic push_err(input int code, input int at_cyc);
    evt_t e;
    e.kind = 1; e.code = code; e.cyc = at_cyc;
    exp_evt.push_back(e);
  endtask

  task automatic push_beat(input logic [7:0] d, input logic l, input logic [7:0] n);
    beat_t b;
    b.data = d; b.last = l; b.len = n;
    exp_beat.push_back(b);
  endtask

  // Called at posedge+1; returns at posedge+1 after the sampling edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},    frm_valid, 0);
    check({tag, "_last"},     frm_last,  0);
    check({tag, "_ok"},       frm_ok,    0);
    check({tag, "_err"},      frm_err,   0);
    check({tag, "_drop"},     drop,      0);
    check({tag, "_len"},      frm_len,   0);
    check({tag, "_err_code"}, err_code,  0);
    check({tag, "_data"},     frm_data,  0);
  endtask

  // Monitor: pops expectations whenever the DUT presents an event or beat.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  logic       prev_last  = 1'b0;

  always @(negedge clk) begin : monitor
    evt_t  e;
    beat_t b;
    if (frm_ok) begin
      if (exp_evt.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL unexpected_ok: got frm_ok=1 expected no event (cycle %0d)", cyc);
      end else begin
        e = exp_evt.pop_front();
        check("ok_kind", 0, e.kind);
        check("ok_with_valid", frm_valid, 1);
      end
    end
    if (frm_err) begin
      if (exp_evt.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL unexpected_err: got frm_err=1 code %0d expected no event (cycle %0d)", err_code, cyc);
      end else begin
        e = exp_evt.pop_front();
        check("err_kind", 1, e.kind);
        check("err_code", err_code, e.code);
        if (e.cyc >= 0) check("err_cycle", cyc, e.cyc);
      end
    end
    if (frm_valid && frm_ready) begin
      if (exp_beat.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL unexpected_beat: got data %0h expected no beat (cycle %0d)", frm_data, cyc);
      end else begin
        b = exp_beat.pop_front();
        check("beat_data", frm_data, b.data);
        check("beat_last", frm_last, b.last);
        check("beat_len",  frm_len,  b.len);
      end
    end
    if (!frm_valid) check("data_zero_idle", frm_data, 0);
    if (prev_stall) begin
      check("hold_valid", frm_valid, 1);
      check("hold_data",  frm_data,  prev_data);
      check("hold_last",  frm_last,  prev_last);
    end
    if (drop) act_drops++;
    prev_stall = frm_valid && !frm_ready;
    prev_data  = frm_data;
    prev_last  = frm_last;
  end

  initial begin : stim
    int t0;
    rst       = 1'b1;
    rx_done   = 1'b0;
    rx_data   = 8'h00;
    frm_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    idle(3);

    // Good frame, LEN 3.
    push_ok();
    push_beat(8'h11, 1'b0, 8'd3);
    push_beat(8'h22, 1'b0, 8'd3);
    push_beat(8'h33, 1'b1, 8'd3);
    send_byte(8'hA5); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
`ifdef UART_FRM_CHK_EN
    send_byte(8'h03);
`endif
    idle(20);

    // Bad checksum (or plain 2-byte frame without checksum), then good frame.
`ifdef UART_FRM_CHK_EN
    push_err(3, -1);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h00);
    idle(5);
    check("err_code_chk", err_code, 3);
`else
    push_ok();
    push_beat(8'h10, 1'b0, 8'd2);
    push_beat(8'h20, 1'b1, 8'd2);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20);
    idle(10);
`endif
    push_ok();
    push_beat(8'h7E, 1'b1, 8'd1);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E);
`ifdef UART_FRM_CHK_EN
    send_byte(8'h7F);
`endif
    idle(10);

    // Noise and bad LEN (0 and MAX_LEN+1).
    push_err(1, -1);
    push_err(1, -1);
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'hA5); send_byte(8'h00);
    send_byte(8'hA5); send_byte(8'h11);
    idle(5);
    check("err_code_len", err_code, 1);

    // Maximum-length frame: payload 80..8F, XOR of payload is 00, so CHK = 10.
    push_ok();
    for (int i = 0; i < 16; i++) push_beat(8'h80 + 8'(i), (i == 15), 8'd16);
    send_byte(8'hA5); send_byte(8'h10);
    for (int i = 0; i < 16; i++) send_byte(8'h80 + 8'(i));
`ifdef UART_FRM_CHK_EN
    send_byte(8'h10);
`endif
    idle(30);

    // Timeout: error exactly TC cycles after the last strobe.
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h44);
    t0 = cyc;
    push_err(2, t0 + TC);
    idle(TC + 10);
    check("err_code_tmo", err_code, 2);

    // Byte arriving in the expiry cycle wins over the timeout.
    push_ok();
    push_beat(8'h44, 1'b0, 8'd2);
    push_beat(8'h55, 1'b1, 8'd2);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h44);
    idle(TC - 1);
    send_byte(8'h55);
`ifdef UART_FRM_CHK_EN
    send_byte(8'h13);
`endif
    idle(10);

    // Backpressure with drops, drop on the final handshake, immediate new header.
    frm_ready = 1'b0;
    push_ok();
    push_beat(8'h5A, 1'b1, 8'd1);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h5A);
`ifdef UART_FRM_CHK_EN
    send_byte(8'h5B);
`endif
    for (int i = 0; i < 50; i++) begin
      if (i == 10 || i == 20 || i == 30) begin
        exp_drops++;
        send_byte((i == 30) ? 8'hA5 : 8'h5A);
      end else begin
        idle(1);
      end
    end
    frm_ready = 1'b1;
    exp_drops++;
    send_byte(8'h33);
    push_ok();
    push_beat(8'h66, 1'b1, 8'd1);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h66);
`ifdef UART_FRM_CHK_EN
    send_byte(8'h67);
`endif
    idle(10);

    // Reset mid-frame, then a full frame.
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    @(posedge clk);
    #1;
    push_ok();
    push_beat(8'hAB, 1'b0, 8'd2);
    push_beat(8'hCD, 1'b1, 8'd2);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAB); send_byte(8'hCD);
`ifdef UART_FRM_CHK_EN
    send_byte(8'h64);
`endif
    idle(20);

    check("evt_queue_empty",  exp_evt.size(),  0);
    check("beat_queue_empty", exp_beat.size(), 0);
    check("drop_count",       act_drops,       exp_drops);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
